// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI target endpoint for modes 0-3 with synchronized SCLK/CS_n/COPI and a one-entry tx holding register.
// Optional macro SPI_PERIPHERAL_CIPO_TRISTATE_EN releases o_cipo (1'bz) while deselected or idle.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_config,
    input  logic [7:0] i_tx,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx,
    output logic       o_rx_valid,
    output logic       o_underrun,
    output logic       o_busy,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_copi,
    output logic       o_cipo
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, copi_q;
    logic sclk_prev, cs_prev, full_q, rx_valid_q, underrun_q, cipo_q;
    logic [1:0] mode_q;
    logic [7:0] hold_q, tx_sh, rx_sh, rx_q, rx_next;
    logic [2:0] cnt_q;
    logic sclk_s, cs_s, copi_s, lead_e, trail_e, sample_e, shift_e, last, load, abort, deselect;

    assign sclk_s   = sclk_q[SYNC_STAGES-1];
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign copi_s   = copi_q[SYNC_STAGES-1];
    assign lead_e   = (sclk_s != sclk_prev) && (sclk_prev == mode_q[1]);
    assign trail_e  = (sclk_s != sclk_prev) && (sclk_s == mode_q[1]);
    assign sample_e = (state_q == SHIFT) && (mode_q[0] ? trail_e : lead_e);
    // CPHA=0: the trailing edge right after a completed byte is skipped; LOAD already presented the new MSB
    assign shift_e  = (state_q == SHIFT) && (mode_q[0] ? lead_e : trail_e) && (mode_q[0] || cnt_q != 3'd0);
    assign last     = sample_e && (cnt_q == 3'd7);
    assign load     = (state_q == LOAD) && !cs_s;
    assign abort    = (state_q != IDLE) && cs_s;
    assign rx_next  = {rx_sh[6:0], copi_s};
    assign deselect = cs_s || (state_q == IDLE);

    always_comb begin
        state_d = (state_q == IDLE) ? ((cs_prev && !cs_s) ? LOAD : IDLE) :
                  cs_s              ? IDLE :
                  (state_q == LOAD) ? SHIFT :
                  last              ? LOAD : state_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_q     <= '0;
            cs_q       <= '1;
            copi_q     <= '0;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            hold_q     <= 8'h00;
            full_q     <= 1'b0;
            tx_sh      <= 8'h00;
            rx_sh      <= 8'h00;
            rx_q       <= 8'h00;
            cnt_q      <= 3'd0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            cipo_q     <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[SYNC_STAGES-2:0], i_sclk};
            cs_q       <= {cs_q[SYNC_STAGES-2:0], i_cs_n};
            copi_q     <= {copi_q[SYNC_STAGES-2:0], i_copi};
            sclk_prev  <= sclk_s;
            cs_prev    <= cs_s;
            state_q    <= state_d;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            if (state_q == IDLE && i_config[0]) mode_q <= i_config[2:1];
            if (i_tx_valid && !full_q) begin
                hold_q <= i_tx;
                full_q <= 1'b1;
            end
            if (sample_e) begin
                rx_sh <= rx_next;
                cnt_q <= cnt_q + 3'd1;
            end
            if (last) begin
                rx_q       <= rx_next;
                rx_valid_q <= 1'b1;
            end
            if (shift_e) begin
                tx_sh  <= {tx_sh[6:0], 1'b0};
                cipo_q <= mode_q[0] ? tx_sh[7] : tx_sh[6];
            end
            if (load) begin
                tx_sh      <= full_q ? hold_q : 8'h00;
                underrun_q <= !full_q;
                cnt_q      <= 3'd0;
                if (full_q) full_q <= 1'b0;
                if (!mode_q[0]) cipo_q <= full_q && hold_q[7];
            end
            if (abort) begin
                tx_sh  <= 8'h00;
                rx_sh  <= 8'h00;
                cnt_q  <= 3'd0;
                cipo_q <= 1'b0;
            end
        end
    end

    assign o_tx_ready = !full_q;
    assign o_rx       = rx_q;
    assign o_rx_valid = rx_valid_q;
    assign o_underrun = underrun_q;
    assign o_busy     = state_q != IDLE;
`ifdef SPI_PERIPHERAL_CIPO_TRISTATE_EN
    assign o_cipo = deselect ? 1'bz : cipo_q;
`else
    assign o_cipo = deselect ? 1'b0 : cipo_q;
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench acting as SPI controller against spi_peripheral.
module tb_spi_peripheral;
    localparam int H = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] cfg = 3'b000;
    logic [7:0] tx = 8'h00;
    logic tx_valid = 1'b0, sclk = 1'b0, cs_n = 1'b1, copi = 1'b0;
    logic tx_ready, rx_valid, underrun, busy, cipo;
    logic [7:0] rx, cap, cap2;
    logic [7:0] rx_log [4];
    int n_cmp = 0, n_err = 0, rxv_cnt = 0, ur_cnt = 0;

    spi_peripheral #(.SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_config(cfg), .i_tx(tx), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx(rx), .o_rx_valid(rx_valid), .o_underrun(underrun),
        .o_busy(busy), .i_sclk(sclk), .i_cs_n(cs_n), .i_copi(copi), .o_cipo(cipo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (rxv_cnt < 4) rx_log[rxv_cnt] = rx;
                rxv_cnt++;
            end
            if (underrun) ur_cnt++;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        cfg = {m, 1'b1};
        tick(1);
        cfg = 3'b000;
        sclk = m[1];
        tick(4);
    endtask

    task automatic load_tx(input logic [7:0] b);
        int k;
        k = 0;
        while (!tx_ready && k < 100) begin
            tick(1);
            k++;
        end
        if (!tx_ready) check("tx_ready_wait", 16'd0, 16'd1);
        tx = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic start_cs();
        rxv_cnt = 0;
        ur_cnt = 0;
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic stop_cs();
        tick(H);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic xfer(input logic [1:0] m, input logic [7:0] b, input int nbits, output logic [7:0] c);
        c = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                copi = b[7-i];
                tick(H);
                c = {c[6:0], cipo};
                sclk = ~m[1];
                tick(H);
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                copi = b[7-i];
                tick(H);
                c = {c[6:0], cipo};
                sclk = m[1];
                tick(H);
            end
        end
    endtask

    initial begin
        tick(3);
        check("rst_rx", rx, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_cipo", cipo, 1'b0);
        rst = 1'b0;
        tick(2);

        set_mode(2'd0);
        load_tx(8'hA5);
        check("m0_hold_full", tx_ready, 1'b0);
        start_cs();
        check("m0_ready_after_load", tx_ready, 1'b1);
        check("m0_busy", busy, 1'b1);
        xfer(2'd0, 8'h3C, 8, cap);
        stop_cs();
        check("m0_rx", rx, 8'h3C);
        check("m0_rx_pulses", rxv_cnt[15:0], 16'd1);
        check("m0_cipo", cap, 8'hA5);

        for (int m = 1; m < 4; m++) begin
            set_mode(m[1:0]);
            load_tx(8'h81);
            start_cs();
            xfer(m[1:0], 8'h7E, 8, cap);
            stop_cs();
            check($sformatf("m%0d_rx", m), rx, 8'h7E);
            check($sformatf("m%0d_cipo", m), cap, 8'h81);
            check($sformatf("m%0d_rx_pulses", m), rxv_cnt[15:0], 16'd1);
        end

        set_mode(2'd0);
        load_tx(8'h55);
        start_cs();
        load_tx(8'hAA);
        xfer(2'd0, 8'h12, 8, cap);
        xfer(2'd0, 8'h34, 8, cap2);
        stop_cs();
        check("b2b_pulses", rxv_cnt[15:0], 16'd2);
        check("b2b_rx0", rx_log[0], 8'h12);
        check("b2b_rx1", rx_log[1], 8'h34);
        check("b2b_cipo0", cap, 8'h55);
        check("b2b_cipo1", cap2, 8'hAA);

        start_cs();
        check("ur_pulse", ur_cnt[15:0], 16'd1);
        xfer(2'd0, 8'h99, 8, cap);
        stop_cs();
        check("ur_cipo", cap, 8'h00);
        check("ur_rx", rx, 8'h99);

        start_cs();
        xfer(2'd0, 8'hFF, 5, cap);
        stop_cs();
        check("abort_no_valid", rxv_cnt[15:0], 16'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_rx_kept", rx, 8'h99);
        start_cs();
        xfer(2'd0, 8'hF0, 8, cap);
        stop_cs();
        check("after_abort_rx", rx, 8'hF0);

        load_tx(8'hE7);
        start_cs();
        cfg = 3'b111;
        tick(1);
        cfg = 3'b000;
        xfer(2'd0, 8'hC3, 8, cap);
        stop_cs();
        check("cfg_shift_rx", rx, 8'hC3);
        check("cfg_shift_cipo", cap, 8'hE7);
        cfg = 3'b111;
        tick(1);
        cfg = 3'b000;
        sclk = 1'b1;
        tick(4);
        load_tx(8'h96);
        start_cs();
        xfer(2'd3, 8'h5A, 8, cap);
        stop_cs();
        check("cfg_idle_rx", rx, 8'h5A);
        check("cfg_idle_cipo", cap, 8'h96);

        load_tx(8'h11);
        start_cs();
        load_tx(8'h22);
        xfer(2'd3, 8'hB4, 4, cap);
        rst = 1'b1;
        tick(1);
        check("mid_rst_rx", rx, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_underrun", underrun, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tx_ready", tx_ready, 1'b1);
        check("mid_rst_cipo", cipo, 1'b0);
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
